// File: rtl/fll_ctrl_pkg.sv
// rtl/fll_ctrl_pkg.sv - shared state encoding and constants for the frequency-lock controller
package fll_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SAR   = 2'd1,
    TRACK = 2'd2
  } fll_state_e;

  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/fll_edge_counter.sv
// rtl/fll_edge_counter.sv - synchronizes the divided VCO clock, detects rising edges, counts them per window
// total_o includes an edge detected in the current cycle; clr_i restarts the count on the next edge.
module fll_edge_counter
  import fll_ctrl_pkg::*;
#(
  parameter int COUNT_BITS = 16
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  clr_i,
  input  logic                  vco_div_i,
  output logic [COUNT_BITS-1:0] total_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [COUNT_BITS-1:0]  cnt_q, cnt_d;
  logic                   edge_det;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], vco_div_i};
    prev_d   = sync_q[SYNC_STAGES-1];
    edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
    total_o  = cnt_q;
    if (edge_det && (cnt_q != '1)) begin
      total_o = cnt_q + 1'b1;
    end
    cnt_d = clr_i ? '0 : total_o;
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/fll_ctrl.sv
// rtl/fll_ctrl.sv - FLL control-word loop: gated edge counting, acquisition, then +/-1 tracking to lock
// Define FLL_CTRL_SAR_EN for successive-approximation acquisition; otherwise tracking starts from the held word.
module fll_ctrl
  import fll_ctrl_pkg::*;
#(
  parameter int RESOLUTION_BITS = 30,
  parameter int COUNT_BITS      = 16,
  parameter int GATE_CYCLES     = 1024,
  parameter int LOCK_TOL        = 1,
  parameter int LOCK_WINDOWS    = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_i,
  input  logic                       en_i,
  input  logic [COUNT_BITS-1:0]      target_count_i,
  input  logic                       vco_div_i,
  output logic [RESOLUTION_BITS-1:0] voltage_ctrl_o,
  output logic [COUNT_BITS-1:0]      count_o,
  output logic                       count_valid_o,
  output logic                       locked_o,
  output logic                       saturated_o
);

  localparam int GATE_W = $clog2(GATE_CYCLES);
  localparam int LOCK_W = $clog2(LOCK_WINDOWS + 1);
  localparam logic [GATE_W-1:0]   GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [LOCK_W-1:0]   LOCK_FULL = LOCK_W'(LOCK_WINDOWS);
  localparam logic [COUNT_BITS:0] TOL_EXT   = (COUNT_BITS + 1)'(LOCK_TOL);

  fll_state_e                 state_q, state_d;
  logic [RESOLUTION_BITS-1:0] ctrl_q, ctrl_d;
  logic [GATE_W-1:0]          gate_q, gate_d;
  logic [COUNT_BITS-1:0]      count_q, count_d;
  logic                       valid_q, valid_d;
  logic [LOCK_W-1:0]          lock_q, lock_d;
  logic                       sat_q, sat_d;
`ifdef FLL_CTRL_SAR_EN
  localparam int IDX_W = $clog2(RESOLUTION_BITS);
  logic [IDX_W-1:0]           idx_q, idx_d;
`endif

  logic                  win_last, cnt_clr, below, in_tol;
  logic [COUNT_BITS-1:0] total;
  logic [COUNT_BITS:0]   total_ext, target_ext, diff;

  assign win_last = (state_q != IDLE) && (gate_q == GATE_LAST);
  assign cnt_clr  = (state_q == IDLE) || win_last;

  fll_edge_counter #(
    .COUNT_BITS(COUNT_BITS)
  ) u_edge_counter (
    .clk_i    (clk_i),
    .arst_i   (arst_i),
    .clr_i    (cnt_clr),
    .vco_div_i(vco_div_i),
    .total_o  (total)
  );

  // One extra bit keeps the error magnitude free of wrap.
  assign total_ext  = {1'b0, total};
  assign target_ext = {1'b0, target_count_i};
  assign below      = total_ext < target_ext;
  assign diff       = below ? (target_ext - total_ext) : (total_ext - target_ext);
  assign in_tol     = diff <= TOL_EXT;

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    gate_d  = gate_q;
    count_d = count_q;
    valid_d = 1'b0;
    lock_d  = lock_q;
    sat_d   = sat_q;
`ifdef FLL_CTRL_SAR_EN
    idx_d   = idx_q;
`endif
    if (!en_i) begin
      state_d = IDLE;
      gate_d  = '0;
      lock_d  = '0;
      sat_d   = 1'b0;
    end else if (state_q == IDLE) begin
      gate_d = '0;
`ifdef FLL_CTRL_SAR_EN
      state_d = SAR;
      ctrl_d  = {1'b1, {(RESOLUTION_BITS-1){1'b0}}};
      idx_d   = IDX_W'(RESOLUTION_BITS - 1);
`else
      state_d = TRACK;
`endif
    end else begin
      gate_d = win_last ? '0 : gate_q + 1'b1;
      if (win_last) begin
        count_d = total;
        valid_d = 1'b1;
        if (state_q == SAR) begin
`ifdef FLL_CTRL_SAR_EN
          if (!below) ctrl_d[idx_q] = 1'b0;
          if (idx_q != '0) begin
            ctrl_d[idx_q - 1'b1] = 1'b1;
            idx_d = idx_q - 1'b1;
          end else begin
            state_d = TRACK;
          end
`endif
        end else if (in_tol) begin
          if (lock_q != LOCK_FULL) lock_d = lock_q + 1'b1;
          sat_d = 1'b0;
        end else begin
          lock_d = '0;
          if (below) begin
            if (ctrl_q == '1) begin
              sat_d = 1'b1;
            end else begin
              ctrl_d = ctrl_q + 1'b1;
              sat_d  = 1'b0;
            end
          end else begin
            if (ctrl_q == '0) begin
              sat_d = 1'b1;
            end else begin
              ctrl_d = ctrl_q - 1'b1;
              sat_d  = 1'b0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q <= IDLE;
      ctrl_q  <= '0;
      gate_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      lock_q  <= '0;
      sat_q   <= 1'b0;
`ifdef FLL_CTRL_SAR_EN
      idx_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      gate_q  <= gate_d;
      count_q <= count_d;
      valid_q <= valid_d;
      lock_q  <= lock_d;
      sat_q   <= sat_d;
`ifdef FLL_CTRL_SAR_EN
      idx_q   <= idx_d;
`endif
    end
  end

  assign voltage_ctrl_o = ctrl_q;
  assign count_o        = count_q;
  assign count_valid_o  = valid_q;
  assign locked_o       = (state_q == TRACK) && (lock_q == LOCK_FULL);
  assign saturated_o    = sat_q;

endmodule

// File: tb/tb_fll_ctrl.sv
// tb/tb_fll_ctrl.sv - closed-loop bench for fll_ctrl with a behavioural VCO and window scoreboard
// Covers both builds; SAR-specific sequences are selected by FLL_CTRL_SAR_EN.
module tb_fll_ctrl;

  localparam int RB = 8, CB = 16, GC = 16, TOL = 1, LW = 4;
  localparam int M_IDLE = 0, M_SAR = 1, M_TRACK = 2;

  logic          clk = 1'b0;
  logic          arst, en, vco;
  logic [CB-1:0] tgt;
  logic [RB-1:0] ctrl;
  logic [CB-1:0] cnt;
  logic          valid, locked, sat;

  fll_ctrl #(
    .RESOLUTION_BITS(RB), .COUNT_BITS(CB), .GATE_CYCLES(GC), .LOCK_TOL(TOL), .LOCK_WINDOWS(LW)
  ) dut (
    .clk_i(clk), .arst_i(arst), .en_i(en), .target_count_i(tgt), .vco_div_i(vco),
    .voltage_ctrl_o(ctrl), .count_o(cnt), .count_valid_o(valid),
    .locked_o(locked), .saturated_o(sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cnt;
    int ctrl;
    bit locked;
    bit sat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   m_state, m_ctrl, m_idx, m_gate, m_cnt, m_lock, m_phase, fix_ph;
  bit   m_sat, fixed_rate, lvl_prev;
  bit   [2:0] rise_hist;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_ctrl = 0; m_idx = 0; m_gate = 0; m_cnt = 0; m_lock = 0;
    m_sat = 0; m_phase = 0; fix_ph = 0; rise_hist = '0; lvl_prev = 0; vco = 1'b0;
    sb.delete();
  endtask

  task automatic window_end();
    exp_t e;
    int d;
    d = m_cnt - int'(tgt);
    if (m_state == M_SAR) begin
      if (m_cnt >= int'(tgt)) m_ctrl &= ~(1 << m_idx);
      if (m_idx > 0) begin
        m_idx--;
        m_ctrl |= (1 << m_idx);
      end else begin
        m_state = M_TRACK;
      end
    end else if (d >= -TOL && d <= TOL) begin
      if (m_lock < LW) m_lock++;
      m_sat = 0;
    end else begin
      m_lock = 0;
      if (d < 0) begin
        if (m_ctrl == (1 << RB) - 1) m_sat = 1;
        else begin m_ctrl++; m_sat = 0; end
      end else begin
        if (m_ctrl == 0) m_sat = 1;
        else begin m_ctrl--; m_sat = 0; end
      end
    end
    e.cnt = m_cnt; e.ctrl = m_ctrl; e.sat = m_sat;
    e.locked = (m_state == M_TRACK) && (m_lock == LW);
    sb.push_back(e);
  endtask

  // A rising edge driven in cycle n lands in the window that contains cycle n+2.
  task automatic model_edge();
    if (!en) begin
      m_state = M_IDLE; m_lock = 0; m_sat = 0;
    end else if (m_state == M_IDLE) begin
`ifdef FLL_CTRL_SAR_EN
      m_state = M_SAR; m_ctrl = 1 << (RB - 1); m_idx = RB - 1;
`else
      m_state = M_TRACK;
`endif
      m_gate = 0; m_cnt = 0;
    end else begin
      m_cnt += int'(rise_hist[2]);
      m_gate++;
      if (m_gate == GC) begin
        window_end();
        m_gate = 0; m_cnt = 0;
      end
    end
  endtask

  task automatic check_dut();
    exp_t e;
    bit exp_valid;
    exp_valid = sb.size() != 0;
    check("valid", valid, exp_valid);
    if (valid && exp_valid) begin
      e = sb.pop_front();
      check("win_count", cnt, e.cnt);
      check("win_ctrl", ctrl, e.ctrl);
      check("win_locked", locked, e.locked);
      check("win_sat", sat, e.sat);
    end
    sb.delete();
    check("ctrl", ctrl, m_ctrl);
    check("locked", locked, (m_state == M_TRACK) && (m_lock == LW));
    check("sat", sat, m_sat);
  endtask

  // VCO period 1024/(ctrl+1) cycles: toggle every 512 units of accumulated ctrl+1.
  task automatic drive_vco();
    bit lvl;
    if (fixed_rate) begin
      fix_ph = (fix_ph + 1) % 4;
      lvl = (fix_ph >= 2);
    end else begin
      m_phase += m_ctrl + 1;
      if (m_phase >= 512) begin
        m_phase -= 512;
        lvl = ~lvl_prev;
      end else begin
        lvl = lvl_prev;
      end
    end
    vco = lvl;
    rise_hist = {rise_hist[1:0], lvl & ~lvl_prev};
    lvl_prev = lvl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (arst) begin
      model_reset();
    end else begin
      model_edge();
      check_dut();
      drive_vco();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int n, nwin, last_v, held, post_sar;
    bit saw_lock;
    arst = 1'b1; en = 1'b0; tgt = '0; fixed_rate = 0;
    model_reset();
    repeat (3) tick();
    check("rst_ctrl", ctrl, 0);
    check("rst_count", cnt, 0);
    check("rst_valid", valid, 0);
    check("rst_locked", locked, 0);
    check("rst_sat", sat, 0);
    arst = 1'b0;
    tick();

    // Fixed period-4 input: four edges in every 16-cycle window.
    fixed_rate = 1; tgt = 4; en = 1'b1;
    nwin = 0; n = 0; last_v = 0;
    while (nwin < 5 && n < 200) begin
      tick(); n++;
      if (valid) begin
        nwin++;
        check("fixed_count", cnt, 4);
        if (last_v > 0) check("fixed_period", cyc - last_v, GC);
        last_v = cyc;
      end
    end
    check("fixed_windows", nwin, 5);

    // Asynchronous reset in the middle of a window.
    repeat (5) tick();
    #3 arst = 1'b1;
    #1;
    check("arst_ctrl", ctrl, 0);
    check("arst_count", cnt, 0);
    check("arst_valid", valid, 0);
    check("arst_locked", locked, 0);
    check("arst_sat", sat, 0);
    model_reset();
    fixed_rate = 0;
    repeat (2) tick();
    arst = 1'b0;

    // Closed loop, target 4.
    tick();
`ifdef FLL_CTRL_SAR_EN
    check("sar_entry", ctrl, 128);
    nwin = 0; n = 0;
    while (nwin < RB && n < 400) begin tick(); n++; if (valid) nwin++; end
    check("sar_windows", nwin, RB);
    post_sar = m_ctrl;
`else
    check("track_entry", ctrl, 0);
    n = 0;
    while (!valid && n < 40) begin tick(); n++; end
    check("ramp_first", ctrl, 1);
    post_sar = 0;
`endif
    n = 0;
    while (!locked && n < 6000) begin tick(); n++; end
    check("lock_reached", locked, 1);
`ifdef FLL_CTRL_SAR_EN
    nwin = 0; n = 0;
    while (nwin < 8 && n < 400) begin
      tick(); n++;
      if (valid) begin
        nwin++;
        check("track_near_sar", (int'(ctrl) >= post_sar - 1) && (int'(ctrl) <= post_sar + 1), 1);
      end
    end
`endif

    // Drop enable from lock: word holds, lock clears on the next edge.
    held = m_ctrl;
    en = 1'b0;
    tick();
    check("idle_hold", ctrl, held);
    check("idle_unlock", locked, 0);
    repeat (20) tick();

    // Re-enable, abort after three windows, re-enable again.
    tgt = 255; en = 1'b1;
    tick();
`ifdef FLL_CTRL_SAR_EN
    check("reenter_sar", ctrl, 128);
`else
    check("reenter_track", ctrl, held);
`endif
    nwin = 0; n = 0;
    while (nwin < 3 && n < 100) begin tick(); n++; if (valid) nwin++; end
    check("abort_windows", nwin, 3);
    held = m_ctrl;
    en = 1'b0;
    tick();
    check("abort_hold", ctrl, held);
    check("abort_locked", locked, 0);
    repeat (10) tick();
    en = 1'b1;
    tick();
`ifdef FLL_CTRL_SAR_EN
    check("abort_reenter", ctrl, 128);
`else
    check("abort_reenter", ctrl, held);
`endif

    // Saturation at all-1s with an unreachable target.
    saw_lock = 0; n = 0;
    while (!sat && n < 6000) begin tick(); n++; saw_lock |= locked; end
    check("sat_reached", sat, 1);
    check("sat_ctrl", ctrl, 255);
    nwin = 0; n = 0;
    while (nwin < 2 && n < 100) begin tick(); n++; saw_lock |= locked; if (valid) nwin++; end
    check("sat_hold", sat, 1);
    check("sat_never_locked", saw_lock, 0);
    en = 1'b0;
    tick();
    check("sat_clear_on_disable", sat, 0);
    check("sat_ctrl_held", ctrl, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
